param_serializer: RTL and testbench
===================================

Name: param_serializer

Overview:
- Parametrised parallel-to-serial converter; successor of the UART TX 8-bit serializer.
- Sits between the UART TX FSM and the output mux.
- Captures a DATA_WIDTH-bit word on a valid handshake and shifts it out one bit per enabled cycle, in either bit order.
- Reports the last bit and a word counter. Optionally generates parity at load time.

Parameters:
- DATA_WIDTH, 8: width of the parallel word; legal range 2..32.
- MSB_FIRST, 0: 0 = LSB shifted out first (UART order); 1 = MSB first.
- CNT_W, $clog2(DATA_WIDTH): width of the bit counter.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  parallel word to serialise.
- Data_Valid  in  1  P_DATA is valid this cycle.
- busy  in  1  FSM frame in progress; blocks loading while high.
- ser_en  in  1  shift enable from the FSM; one bit per high cycle.
- par_type  in  1  0 = even parity, 1 = odd parity (used only with SER_PARITY_EN).
- ser_data  out  1  current serial bit.
- ser_done  out  1  high while the last bit of the word is on ser_data and ser_en is high.
- bit_cnt  out  CNT_W  index of the bit currently presented.
- par_bit  out  1  registered parity of the loaded word.

Behaviour:
- Reset (rst=1 at posedge):
  - shift_reg=0, bit_cnt=0, par_bit=0, so ser_data=0 and ser_done=0.
  - Reset overrides load and shift in the same cycle. Asserting it mid-word aborts the word and does not resume it.
- Load (Data_Valid=1 and busy=0 at posedge):
  - shift_reg<=P_DATA, bit_cnt<=0.
  - ser_data shows bit 0 (LSB-first) or bit DATA_WIDTH-1 (MSB-first) in the next cycle. Latency from load to first bit is 1 clk.
- Priority: rst > load > shift. Load with ser_en=1 in the same cycle reloads and restarts the count; no shift occurs that cycle.
- Shift (ser_en=1, no load):
  - LSB-first: shift_reg shifts right with 0 filled at the MSB. MSB-first: shifts left with 0 filled at the LSB.
  - bit_cnt increments. At DATA_WIDTH-1 it wraps to 0 on the next shift; no overflow past the word.
- Idle (ser_en=0, no load): shift_reg holds its value; bit_cnt clears to 0.
- ser_done is combinational: (bit_cnt==DATA_WIDTH-1) & ser_en.
  - It is high for exactly one cycle per word when ser_en is held continuously.
  - Dropping ser_en mid-word restarts the count but not the data. The FSM must reload before reusing the word.
- Data_Valid while busy=1: ignored; the in-flight word is not disturbed.
- All outputs are glitch-free registered values, except ser_done (a single AND of registered state and ser_en).

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: on load, par_bit <= ^P_DATA ^ par_type, giving even parity for par_type=0 and odd for par_type=1. par_bit holds until the next load or reset.
- Undefined: par_bit is tied to 0, the parity logic is not built, and par_type is unused.

Test Plan:
- Reset: hold rst=1 for 3 clk with Data_Valid=1 and P_DATA=8'hFF -> ser_data=0, bit_cnt=0, ser_done=0, par_bit=0.
- LSB-first: DATA_WIDTH=8, load 8'hA5 with busy=0, then ser_en=1 for 8 clk:
  - ser_data sequence is 1,0,1,0,0,1,0,1.
  - ser_done is high only in the 8th cycle; bit_cnt reads 0..7 and then wraps to 0.
- MSB-first: MSB_FIRST=1, DATA_WIDTH=12, load 12'hC03, ser_en=1 for 12 clk:
  - ser_data sequence is 1,1,0,0,0,0,0,0,0,0,1,1.
  - ser_done is high in cycle 12.
- Load blocking: load 8'h3C, raise busy=1, then present Data_Valid=1 with P_DATA=8'hFF during the shift -> output stream is still that of 8'h3C.
- Collision: Data_Valid=1, busy=0 and ser_en=1 in the same cycle while at bit 4 -> new word loaded and bit_cnt=0 next cycle; the old word's remaining bits are never output.
- Parity (SER_PARITY_EN defined):
  - load 8'h07 with par_type=0 -> par_bit=1.
  - load 8'h07 with par_type=1 -> par_bit=0.
  - With the macro undefined, par_bit=0 for both.

Source files
------------

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: loads a DATA_WIDTH-bit word on Data_Valid & ~busy and
// shifts one bit per ser_en cycle, LSB- or MSB-first. Define SER_PARITY_EN for load-time parity.
module param_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  busy,
    input  logic                  ser_en,
    input  logic                  par_type,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  par_bit
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic                  load;

    // A load is only accepted between frames; Data_Valid during a frame is dropped.
    assign load = Data_Valid & ~busy;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign shifted = {1'b0, shift_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        if (load) begin
            shift_next = P_DATA;
            cnt_next   = '0;
        end else if (ser_en) begin
            shift_next = shifted;
            cnt_next   = (cnt_reg == LAST_IDX) ? '0 : cnt_reg + CNT_W'(1);
        end else begin
            // Pausing restarts the index but keeps the partially shifted data.
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ser_data = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
    assign ser_done = (cnt_reg == LAST_IDX) & ser_en;
    assign bit_cnt  = cnt_reg;

`ifdef SER_PARITY_EN
    logic par_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else if (load) begin
            par_reg <= (^P_DATA) ^ par_type;
        end
    end

    assign par_bit = par_reg;
`else
    logic unused_par_type;
    assign unused_par_type = par_type;
    assign par_bit         = 1'b0;
`endif

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: an 8-bit LSB-first and a 12-bit MSB-first instance
// on a shared clock/reset. Parity expectations follow SER_PARITY_EN.
module tb_param_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        par_type;

    logic [7:0]  d8;
    logic        dv8, busy8, en8;
    logic        ser_data8, ser_done8, par_bit8;
    logic [2:0]  bit_cnt8;

    logic [11:0] d12;
    logic        dv12, busy12, en12;
    logic        ser_data12, ser_done12, par_bit12;
    logic [3:0]  bit_cnt12;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .P_DATA(d8), .Data_Valid(dv8), .busy(busy8),
        .ser_en(en8), .par_type(par_type), .ser_data(ser_data8),
        .ser_done(ser_done8), .bit_cnt(bit_cnt8), .par_bit(par_bit8)
    );

    param_serializer #(.DATA_WIDTH(12), .MSB_FIRST(1'b1)) dut12 (
        .clk(clk), .rst(rst), .P_DATA(d12), .Data_Valid(dv12), .busy(busy12),
        .ser_en(en12), .par_type(par_type), .ser_data(ser_data12),
        .ser_done(ser_done12), .bit_cnt(bit_cnt12), .par_bit(par_bit12)
    );

`ifdef SER_PARITY_EN
    localparam logic PAR_07_EVEN = 1'b1;
    localparam logic PAR_07_ODD  = 1'b0;
`else
    localparam logic PAR_07_EVEN = 1'b0;
    localparam logic PAR_07_ODD  = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the 8-bit instance over stream positions [first,last); stream is written first-bit-leftmost.
    task automatic shift8(input string tag, input logic [7:0] stream, input int first, input int last);
        for (int i = first; i < last; i++) begin
            en8 = 1'b1;
            #1;
            chk($sformatf("%s data[%0d]", tag, i), ser_data8, stream[7-i]);
            chk($sformatf("%s cnt[%0d]", tag, i), bit_cnt8, i);
            chk($sformatf("%s done[%0d]", tag, i), ser_done8, (i == 7));
            tick();
        end
    endtask

    task automatic load8(input logic [7:0] w);
        dv8 = 1'b1; d8 = w; busy8 = 1'b0; en8 = 1'b0;
        tick();
        dv8 = 1'b0;
        $display("load8  word=%02h par_type=%0b", w, par_type);
    endtask

    initial begin
        rst = 1'b1; par_type = 1'b0;
        d8 = 8'hFF; dv8 = 1'b1; busy8 = 1'b0; en8 = 1'b1;
        d12 = 12'hFFF; dv12 = 1'b1; busy12 = 1'b0; en12 = 1'b1;

        // Reset dominates a simultaneous load and shift.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst data8", ser_data8, 1'b0);
            chk("rst cnt8", bit_cnt8, 3'd0);
            chk("rst done8", ser_done8, 1'b0);
            chk("rst par8", par_bit8, 1'b0);
            chk("rst data12", ser_data12, 1'b0);
            chk("rst cnt12", bit_cnt12, 4'd0);
        end
        $display("reset  held 3 clk with Data_Valid=1 P_DATA=all ones");
        rst = 1'b0; dv8 = 1'b0; en8 = 1'b0; dv12 = 1'b0; en12 = 1'b0;

        // LSB-first 8'hA5: stream 1,0,1,0,0,1,0,1, then wrap.
        load8(8'hA5);
        shift8("lsb_a5", 8'b1010_0101, 0, 8);
        en8 = 1'b0; #1;
        chk("lsb_a5 wrap cnt", bit_cnt8, 3'd0);
        chk("lsb_a5 wrap done", ser_done8, 1'b0);

        // MSB-first 12'hC03: stream 1,1,0,0,0,0,0,0,0,0,1,1.
        dv12 = 1'b1; d12 = 12'hC03; tick(); dv12 = 1'b0;
        $display("load12 word=c03");
        for (int i = 0; i < 12; i++) begin
            logic [11:0] s12;
            s12 = 12'b1100_0000_0011;
            en12 = 1'b1; #1;
            chk($sformatf("msb_c03 data[%0d]", i), ser_data12, s12[11-i]);
            chk($sformatf("msb_c03 cnt[%0d]", i), bit_cnt12, i);
            chk($sformatf("msb_c03 done[%0d]", i), ser_done12, (i == 11));
            tick();
        end
        en12 = 1'b0; #1;
        chk("msb_c03 wrap cnt", bit_cnt12, 4'd0);

        // Load blocked while busy: 8'h3C stream 0,0,1,1,1,1,0,0 survives an 8'hFF offer.
        load8(8'h3C);
        busy8 = 1'b1;
        shift8("busy_3c", 8'b0011_1100, 0, 2);
        dv8 = 1'b1; d8 = 8'hFF;
        shift8("busy_3c", 8'b0011_1100, 2, 8);
        dv8 = 1'b0; busy8 = 1'b0; en8 = 1'b0;
        $display("busy   offered ff during 3c frame");

        // Collision at bit 4: 8'h96 (0,1,1,0,1,...) replaced by 8'h0F (1,1,1,1,0,0,0,0).
        load8(8'h96);
        shift8("col_96", 8'b0110_1001, 0, 4);
        dv8 = 1'b1; d8 = 8'h0F; en8 = 1'b1; #1;
        chk("col_96 cnt at collide", bit_cnt8, 3'd4);
        chk("col_96 data at collide", ser_data8, 1'b1);
        tick();
        dv8 = 1'b0;
        $display("load8  word=0f collided with ser_en at bit 4");
        shift8("col_0f", 8'b1111_0000, 0, 8);
        en8 = 1'b0;

        // Pause mid-word: count restarts, data holds (8'h06 at bit 2 shows 1).
        load8(8'h06);
        shift8("idle_06", 8'b0110_0000, 0, 2);
        en8 = 1'b0; #1;
        chk("idle_06 done paused", ser_done8, 1'b0);
        tick();
        chk("idle_06 cnt cleared", bit_cnt8, 3'd0);
        chk("idle_06 data held", ser_data8, 1'b1);
        tick();
        chk("idle_06 data still held", ser_data8, 1'b1);

        // Reset mid-word aborts and does not resume.
        load8(8'hFF);
        shift8("abort_ff", 8'hFF, 0, 3);
        rst = 1'b1; dv8 = 1'b1; d8 = 8'hFF; en8 = 1'b1;
        tick();
        rst = 1'b0; dv8 = 1'b0; #1;
        chk("abort data", ser_data8, 1'b0);
        chk("abort cnt", bit_cnt8, 3'd0);
        tick();
        chk("abort no resume data", ser_data8, 1'b0);
        chk("abort no resume cnt", bit_cnt8, 3'd1);
        en8 = 1'b0;
        $display("abort  reset asserted at bit 3 of ff");

        // Parity of 8'h07 (three ones).
        par_type = 1'b0;
        load8(8'h07);
        chk("par 07 even", par_bit8, PAR_07_EVEN);
        par_type = 1'b1;
        shift8("par_hold", 8'b1110_0000, 0, 3);
        chk("par 07 held", par_bit8, PAR_07_EVEN);
        en8 = 1'b0;
        load8(8'h07);
        chk("par 07 odd", par_bit8, PAR_07_ODD);
        chk("par12 after rst", par_bit12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
